// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the IF stage, the decode stage and the instruction SRAM.
// master = fetch unit side, slave = decode/SRAM side.
interface if_fetch_unit_if;
   logic [32:0] br_bus;           // {br_e, br_addr[31:0]} from decode
   logic [32:0] if_to_id_bus;     // {ce, pc[31:0]} to decode
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;

   modport master (
      input  br_bus,
      output if_to_id_bus,
      output inst_sram_en,
      output inst_sram_wen,
      output inst_sram_addr,
      output inst_sram_wdata
   );

   modport slave (
      output br_bus,
      input  if_to_id_bus,
      input  inst_sram_en,
      input  inst_sram_wen,
      input  inst_sram_addr,
      input  inst_sram_wdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction
// SRAM request port and hands {ce, pc} to decode. A branch that arrives while
// IF is stalled is held in a one-entry pending buffer until the stall drops.
// Optional build macro IF_ADDR_ALIGN_CHECK_EN: flag misaligned fetch addresses
// on if_excp and suppress the SRAM request for them.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          STALL_WD = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [31:0]         new_pc,
   input  logic [STALL_WD-1:0] stall,
   if_fetch_unit_if.master     bus,
   output logic                if_excp
);

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      HOLD    = 2'd2,
      HOLD_BR = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        ce_q, ce_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic        excp_q;

   logic        stop_if;
   logic        br_e;
   logic [31:0] br_addr;
   logic [31:0] pc_inc;
   logic        fetch_ok;

   // Only stall[0] concerns IF; the other stage bits are deliberately ignored.
   logic        unused_stall;
   assign unused_stall = ^stall[STALL_WD-1:1];

   assign stop_if = stall[0];
   assign br_e    = bus.br_bus[32];
   assign br_addr = bus.br_bus[31:0];
   assign pc_inc  = pc_q + 32'd4;   // wraps mod 2^32

   // Next-state logic: flush overrides everything below reset, including stalls.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ce_d        = ce_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      if (flush) begin
         pc_d    = new_pc;
         ce_d    = 1'b1;
         pend_d  = 1'b0;
         state_d = RUN;
      end else begin
         case (state_q)
            BOOT: begin
               pc_d    = RESET_PC;
               ce_d    = 1'b1;
               state_d = RUN;
            end
            RUN: begin
               if (!stop_if) begin
                  pc_d = br_e ? br_addr : pc_inc;
               end else if (br_e) begin
                  pend_d      = 1'b1;
                  pend_addr_d = br_addr;
                  state_d     = HOLD_BR;
               end else begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (br_e) begin
                  pend_d      = 1'b1;
                  pend_addr_d = br_addr;
                  state_d     = HOLD_BR;
               end else if (!stop_if) begin
                  pc_d    = pc_inc;
                  state_d = RUN;
               end
            end
            HOLD_BR: begin
               // First captured redirect wins; later br_e pulses are dropped.
               if (!stop_if) begin
                  pc_d    = pend_addr_q;
                  pend_d  = 1'b0;
                  state_d = RUN;
               end
            end
            default: begin
               state_d = BOOT;
            end
         endcase
      end
   end

   // FSM and PC registers; the alignment flag is registered alongside the PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC - 32'd4;
         ce_q        <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= 32'd0;
         excp_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ce_q        <= ce_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
`ifdef IF_ADDR_ALIGN_CHECK_EN
         excp_q      <= ce_d & (pc_d[1:0] != 2'b00);
`else
         excp_q      <= 1'b0;
`endif
      end
   end

   // A misaligned PC is still forwarded (for BadVAddr) but never requested.
   assign fetch_ok = ce_q & ~excp_q;

   assign bus.if_to_id_bus    = {fetch_ok, pc_q};
   assign bus.inst_sram_en    = fetch_ok;
   assign bus.inst_sram_wen   = 4'b0000;
   assign bus.inst_sram_addr  = pc_q;
   assign bus.inst_sram_wdata = 32'd0;
   assign if_excp             = excp_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model
// that tracks the PC, a pending-redirect queue and a "held" flag.
module tb_if_fetch_unit;

   localparam logic [31:0] RPC = 32'hBFC0_0000;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [31:0] new_pc;
   logic [5:0]  stall;
   logic        br_e;
   logic [31:0] br_addr;
   logic        if_excp;

   int n_vec;
   int n_err;

   if_fetch_unit_if bus_if ();
   assign bus_if.br_bus = {br_e, br_addr};

   if_fetch_unit #(.RESET_PC(RPC), .STALL_WD(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .new_pc (new_pc),
      .stall  (stall),
      .bus    (bus_if),
      .if_excp(if_excp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: what the fetch address must be after each edge.
   logic [31:0] m_pc;
   logic        m_ce;
   logic        m_boot;
   logic        m_held;
   logic        m_valid;
   logic [31:0] m_pend[$];

   initial m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_pc    = RPC - 32'd4;
         m_ce    = 1'b0;
         m_boot  = 1'b1;
         m_held  = 1'b0;
         m_pend.delete();
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (flush) begin
            m_pc   = new_pc;
            m_ce   = 1'b1;
            m_boot = 1'b0;
            m_held = 1'b0;
            m_pend.delete();
         end else if (m_boot) begin
            m_pc   = RPC;
            m_ce   = 1'b1;
            m_boot = 1'b0;
         end else if (m_pend.size() > 0) begin
            if (!stall[0]) begin
               m_pc   = m_pend.pop_front();
               m_held = 1'b0;
            end
         end else if (m_held) begin
            if (br_e) m_pend.push_back(br_addr);
            else if (!stall[0]) begin
               m_pc   = m_pc + 32'd4;
               m_held = 1'b0;
            end
         end else begin
            if (!stall[0]) m_pc = br_e ? br_addr : m_pc + 32'd4;
            else if (br_e) begin
               m_pend.push_back(br_addr);
               m_held = 1'b1;
            end else m_held = 1'b1;
         end
      end
   end

   function automatic logic model_excp();
`ifdef IF_ADDR_ALIGN_CHECK_EN
      return m_ce & (m_pc[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   // Every-cycle comparison, sampled mid-cycle.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("addr",  bus_if.inst_sram_addr, m_pc);
         chk("en",    bus_if.inst_sram_en, m_ce & ~model_excp());
         chk("id_bus", bus_if.if_to_id_bus, {m_ce & ~model_excp(), m_pc});
         chk("wen",   bus_if.inst_sram_wen, 4'b0000);
         chk("wdata", bus_if.inst_sram_wdata, 32'd0);
         chk("excp",  if_excp, model_excp());
      end
   end

   // Apply one cycle of inputs, then return just after the edge.
   task automatic step(input logic r, input logic f, input logic [31:0] np,
                       input logic s, input logic be, input logic [31:0] ba);
      rst     = r;
      flush   = f;
      new_pc  = np;
      stall   = {5'b0, s};
      br_e    = be;
      br_addr = ba;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      flush   = 1'b0;
      new_pc  = 32'd0;
      stall   = 6'd0;
      br_e    = 1'b0;
      br_addr = 32'd0;

      // Reset and release
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      chk("rst_addr", bus_if.inst_sram_addr, 32'hBFBF_FFFC);
      chk("rst_en",   bus_if.inst_sram_en, 1'b0);
      chk("rst_bus",  bus_if.if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
      chk("rst_excp", if_excp, 1'b0);
      idle();
      chk("boot_addr", bus_if.inst_sram_addr, 32'hBFC0_0000);
      chk("boot_en",   bus_if.inst_sram_en, 1'b1);
      idle();
      chk("seq_addr", bus_if.inst_sram_addr, 32'hBFC0_0004);
      idle(); idle(); idle();
      chk("pre_br", bus_if.inst_sram_addr, 32'hBFC0_0010);

      // Branch without stall
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBFC0_0100);
      chk("br_tgt", bus_if.inst_sram_addr, 32'hBFC0_0100);
      idle();
      chk("br_seq", bus_if.inst_sram_addr, 32'hBFC0_0104);

      // Branch during a 3-cycle stall
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0040);
      chk("st_hold1", bus_if.inst_sram_addr, 32'hBFC0_0104);
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      chk("st_hold2", bus_if.inst_sram_addr, 32'hBFC0_0104);
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1234_5678);
      chk("st_hold3", bus_if.inst_sram_addr, 32'hBFC0_0104);
      idle();
      chk("st_tgt", bus_if.inst_sram_addr, 32'h8000_0040);
      idle();
      chk("st_seq", bus_if.inst_sram_addr, 32'h8000_0044);

      // Flush beats a pending branch
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0040);
      step(1'b0, 1'b1, 32'hBFC0_0380, 1'b1, 1'b1, 32'h9000_0000);
      chk("fl_tgt", bus_if.inst_sram_addr, 32'hBFC0_0380);
      idle();
      chk("fl_seq", bus_if.inst_sram_addr, 32'hBFC0_0384);

      // Address wrap
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
      chk("wrap_top", bus_if.inst_sram_addr, 32'hFFFF_FFFC);
      idle();
      chk("wrap_zero", bus_if.inst_sram_addr, 32'h0000_0000);

      // Misaligned branch target
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_0042);
      chk("mis_pc", bus_if.inst_sram_addr, 32'h8000_0042);
`ifdef IF_ADDR_ALIGN_CHECK_EN
      chk("mis_excp", if_excp, 1'b1);
      chk("mis_en",   bus_if.inst_sram_en, 1'b0);
      chk("mis_bus",  bus_if.if_to_id_bus, {1'b0, 32'h8000_0042});
`else
      chk("mis_excp", if_excp, 1'b0);
      chk("mis_en",   bus_if.inst_sram_en, 1'b1);
      chk("mis_bus",  bus_if.if_to_id_bus, {1'b1, 32'h8000_0042});
`endif
      step(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 32'd0);

      // Reset while a branch is pending
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_1000);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      chk("rstp_addr", bus_if.inst_sram_addr, 32'hBFBF_FFFC);
      chk("rstp_en",   bus_if.inst_sram_en, 1'b0);
      idle();
      chk("rstp_boot", bus_if.inst_sram_addr, 32'hBFC0_0000);

      // Flush during BOOT skips the reset-vector fetch
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 32'h8000_0180, 1'b0, 1'b0, 32'd0);
      chk("bootfl", bus_if.inst_sram_addr, 32'h8000_0180);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic        r, f, s, be;
         logic [31:0] np, ba;
         r  = ($urandom_range(0, 99) == 0);
         f  = ($urandom_range(0, 19) == 0);
         s  = ($urandom_range(0, 9) < 4);
         be = ($urandom_range(0, 3) == 0);
         np = $urandom & 32'hFFFF_FFFC;
         ba = $urandom;
         if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
         step(r, f, np, s, be, ba);
         stall[5:1] = 5'($urandom);
      end

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
